// File: rtl/v850_pkg.sv
// v850_pkg
//   Shared types and constants for the V850 exception sequencer slice:
//   sequencer state encoding, exception kinds (ordered by priority),
//   return-kind encodings, PSW bit positions and default handler vectors.
package v850_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE,
    ST_PSWUPD,
    ST_REDIR,
    ST_RESTORE
  } seq_state_t;

  // Numeric order of the encodings is the priority order (DB highest),
  // so a plain magnitude compare picks the more urgent kind.
  typedef enum logic [1:0] {
    EXC_EI = 2'd0,
    EXC_FE = 2'd1,
    EXC_DB = 2'd2
  } exc_kind_t;

  localparam logic [1:0] RET_EIRET = 2'd0;
  localparam logic [1:0] RET_FERET = 2'd1;
  localparam logic [1:0] RET_DBRET = 2'd2;

  localparam int unsigned PSW_ID = 5;
  localparam int unsigned PSW_EP = 6;
  localparam int unsigned PSW_NP = 7;

  localparam logic [31:0] VEC_EI_DEF = 32'h0000_0080;
  localparam logic [31:0] VEC_FE_DEF = 32'h0000_0060;
  localparam logic [31:0] VEC_DB_DEF = 32'h0000_0040;

  // Map a raw return kind onto a legal one; the reserved code 3 behaves as EIRET.
  function automatic logic [1:0] legal_ret_kind(input logic [1:0] rk);
    return (rk == 2'd3) ? RET_EIRET : rk;
  endfunction

endpackage

// File: rtl/v850_exc_pick.sv
// v850_exc_pick
//   Combinational masking and priority selection of pending exception
//   requests against the current PSW.
//   Inputs : ei/fe/db_req level requests, their 16-bit cause codes, psw.
//   Outputs: vld (some request is eligible), kind (winner), code (winner cause).
//   Eligibility: DB always; FE when NP=0; EI when ID=0 and NP=0.
//   Priority: DB > FE > EI.
module v850_exc_pick
  import v850_pkg::*;
(
  input  logic        ei_req,
  input  logic        fe_req,
  input  logic        db_req,
  input  logic [15:0] ei_code,
  input  logic [15:0] fe_code,
  input  logic [15:0] db_code,
  input  logic [31:0] psw,
  output logic        vld,
  output exc_kind_t   kind,
  output logic [15:0] code
);

  logic fe_ok;
  logic ei_ok;

  always_comb begin
    fe_ok = ~psw[PSW_NP];
    ei_ok = ~psw[PSW_NP] & ~psw[PSW_ID];
    vld   = 1'b0;
    kind  = EXC_EI;
    code  = '0;
    if (db_req) begin
      vld  = 1'b1;
      kind = EXC_DB;
      code = db_code;
    end else if (fe_req && fe_ok) begin
      vld  = 1'b1;
      kind = EXC_FE;
      code = fe_code;
    end else if (ei_req && ei_ok) begin
      vld  = 1'b1;
      kind = EXC_EI;
      code = ei_code;
    end
  end

endmodule

// File: rtl/v850_exc_seq.sv
// v850_exc_seq
//   Exception entry / return sequencer. Arbitrates EI/FE/DB entries and
//   EIRET/FERET/DBRET returns, stalls until the pipeline drains, then
//   writes the save bank, updates PSW and redirects the PC.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     *_req / *_code / *_ack     exception request, cause, completion pulse
//     ret_req/ret_kind/ret_ack   return request, kind, completion pulse
//     cur_pc, cur_psw            live state to save / modify
//     eipc..dbpsw                saved-state read values for returns
//     pipe_idle                  pipeline drained
//     stall                      hold fetch/issue while sequencing
//     save_we/sel/pc/psw/cause   save-bank write
//     psw_we/psw_wdata           PSW write
//     redir_vld/redir_pc         PC redirect
module v850_exc_seq
  import v850_pkg::*;
#(
  parameter logic [31:0] VEC_EI = VEC_EI_DEF,
  parameter logic [31:0] VEC_FE = VEC_FE_DEF,
  parameter logic [31:0] VEC_DB = VEC_DB_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ei_req,
  input  logic        fe_req,
  input  logic        db_req,
  input  logic [15:0] ei_code,
  input  logic [15:0] fe_code,
  input  logic [15:0] db_code,
  output logic        ei_ack,
  output logic        fe_ack,
  output logic        db_ack,
  input  logic        ret_req,
  input  logic [1:0]  ret_kind,
  output logic        ret_ack,
  input  logic [31:0] cur_pc,
  input  logic [31:0] cur_psw,
  input  logic [31:0] eipc,
  input  logic [31:0] eipsw,
  input  logic [31:0] fepc,
  input  logic [31:0] fepsw,
  input  logic [31:0] dbpc,
  input  logic [31:0] dbpsw,
  input  logic        pipe_idle,
  output logic        stall,
  output logic        save_we,
  output logic [1:0]  save_sel,
  output logic [31:0] save_pc,
  output logic [31:0] save_psw,
  output logic [15:0] save_cause,
  output logic        psw_we,
  output logic [31:0] psw_wdata,
  output logic        redir_vld,
  output logic [31:0] redir_pc
);

  seq_state_t  state_q, state_d;
  exc_kind_t   kind_q, kind_d;
  logic [15:0] code_q, code_d;
  logic        is_ret_q, is_ret_d;
  logic [1:0]  rkind_q, rkind_d;

  logic        pick_vld;
  exc_kind_t   pick_kind;
  logic [15:0] pick_code;

  v850_exc_pick u_pick (
    .ei_req  (ei_req),
    .fe_req  (fe_req),
    .db_req  (db_req),
    .ei_code (ei_code),
    .fe_code (fe_code),
    .db_code (db_code),
    .psw     (cur_psw),
    .vld     (pick_vld),
    .kind    (pick_kind),
    .code    (pick_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      kind_q   <= EXC_EI;
      code_q   <= '0;
      is_ret_q <= 1'b0;
      rkind_q  <= RET_EIRET;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      code_q   <= code_d;
      is_ret_q <= is_ret_d;
      rkind_q  <= rkind_d;
    end
  end

  // Next state and latched request bookkeeping.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    code_d   = code_q;
    is_ret_d = is_ret_q;
    rkind_d  = rkind_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          kind_d   = pick_kind;
          code_d   = pick_code;
          is_ret_d = 1'b0;
          state_d  = ST_DRAIN;
        end else if (ret_req) begin
          rkind_d  = legal_ret_kind(ret_kind);
          is_ret_d = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Any eligible exception preempts a pending return; among
        // exceptions only a strictly higher-priority kind replaces.
        // Replacement and the drain exit may happen in the same cycle.
        if (pick_vld && (is_ret_q || (pick_kind > kind_q))) begin
          kind_d   = pick_kind;
          code_d   = pick_code;
          is_ret_d = 1'b0;
        end
        if (pipe_idle) begin
          state_d = is_ret_d ? ST_RESTORE : ST_SAVE;
        end
      end
      ST_SAVE:    state_d = ST_PSWUPD;
      ST_PSWUPD:  state_d = ST_REDIR;
      ST_REDIR:   state_d = ST_IDLE;
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  logic [31:0] ei_vec;

  // Outputs decode from the registered state only, so an asynchronous
  // reset clears every strobe within the same cycle.
  always_comb begin
    ei_vec     = VEC_EI + {22'd0, code_q[5:0], 4'h0};
    stall      = (state_q != ST_IDLE);
    save_we    = 1'b0;
    save_sel   = '0;
    save_pc    = '0;
    save_psw   = '0;
    save_cause = '0;
    psw_we     = 1'b0;
    psw_wdata  = '0;
    redir_vld  = 1'b0;
    redir_pc   = '0;
    ei_ack     = 1'b0;
    fe_ack     = 1'b0;
    db_ack     = 1'b0;
    ret_ack    = 1'b0;
    unique case (state_q)
      ST_SAVE: begin
        save_we    = 1'b1;
        save_sel   = kind_q;
        save_pc    = cur_pc;
        save_psw   = cur_psw;
        save_cause = code_q;
      end
      ST_PSWUPD: begin
        psw_we            = 1'b1;
        psw_wdata         = cur_psw;
        psw_wdata[PSW_ID] = 1'b1;
        if (kind_q != EXC_EI) begin
          psw_wdata[PSW_NP] = 1'b1;
        end
      end
      ST_REDIR: begin
        redir_vld = 1'b1;
        unique case (kind_q)
          EXC_FE: begin
            redir_pc = VEC_FE;
            fe_ack   = 1'b1;
          end
          EXC_DB: begin
            redir_pc = VEC_DB;
            db_ack   = 1'b1;
          end
          default: begin
            redir_pc = ei_vec;
            ei_ack   = 1'b1;
          end
        endcase
        redir_pc[0] = 1'b0;
      end
      ST_RESTORE: begin
        psw_we    = 1'b1;
        redir_vld = 1'b1;
        ret_ack   = 1'b1;
        unique case (rkind_q)
          RET_FERET: begin
            psw_wdata = fepsw;
            redir_pc  = fepc;
          end
          RET_DBRET: begin
            psw_wdata = dbpsw;
            redir_pc  = dbpc;
          end
          default: begin
            psw_wdata = eipsw;
            redir_pc  = eipc;
          end
        endcase
        redir_pc[0] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_v850_exc_seq.sv
// tb_v850_exc_seq
//   Self-checking bench: directed scenarios plus randomized transactions,
//   each predicted by a transaction-level model (priority rank arithmetic
//   and a fixed cycle timeline measured from the drain completion).
module tb_v850_exc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ei_req, fe_req, db_req;
  logic [15:0] ei_code, fe_code, db_code;
  logic        ei_ack, fe_ack, db_ack;
  logic        ret_req;
  logic [1:0]  ret_kind;
  logic        ret_ack;
  logic [31:0] cur_pc, cur_psw;
  logic [31:0] eipc, eipsw, fepc, fepsw, dbpc, dbpsw;
  logic        pipe_idle;
  logic        stall, save_we, psw_we, redir_vld;
  logic [1:0]  save_sel;
  logic [31:0] save_pc, save_psw, psw_wdata, redir_pc;
  logic [15:0] save_cause;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  v850_exc_seq dut (
    .clk(clk), .rst_n(rst_n),
    .ei_req(ei_req), .fe_req(fe_req), .db_req(db_req),
    .ei_code(ei_code), .fe_code(fe_code), .db_code(db_code),
    .ei_ack(ei_ack), .fe_ack(fe_ack), .db_ack(db_ack),
    .ret_req(ret_req), .ret_kind(ret_kind), .ret_ack(ret_ack),
    .cur_pc(cur_pc), .cur_psw(cur_psw),
    .eipc(eipc), .eipsw(eipsw), .fepc(fepc), .fepsw(fepsw),
    .dbpc(dbpc), .dbpsw(dbpsw),
    .pipe_idle(pipe_idle), .stall(stall),
    .save_we(save_we), .save_sel(save_sel), .save_pc(save_pc),
    .save_psw(save_psw), .save_cause(save_cause),
    .psw_we(psw_we), .psw_wdata(psw_wdata),
    .redir_vld(redir_vld), .redir_pc(redir_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_flags();
    return {24'd0, stall, save_we, psw_we, redir_vld, ei_ack, fe_ack, db_ack, ret_ack};
  endfunction

  function automatic logic [31:0] out_data_or();
    return save_pc | save_psw | psw_wdata | redir_pc | {14'd0, save_sel, save_cause};
  endfunction

  // rank: 1=EI 2=FE 3=DB
  function automatic bit eligible(input int r, input logic [31:0] psw);
    case (r)
      3: return 1'b1;
      2: return !psw[7];
      1: return !psw[5] && !psw[7];
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_req(input int r, input logic v);
    case (r)
      1: ei_req = v;
      2: fe_req = v;
      3: db_req = v;
      default: ;
    endcase
  endtask

  // Starts 1 time unit after a rising edge with the DUT idle; leaves the bench
  // at the same point of the cycle in which the DUT is idle again.
  // req = {ret, db, fe, ei}
  task automatic run_txn(input string tag, input logic [31:0] psw, input logic [3:0] req,
                         input logic [1:0] rk, input int d, input int late_rank,
                         input int late_cyc, input bit drop1);
    int win;
    int end_c;
    bit exc;
    logic [15:0] code;
    logic [31:0] vec, rpc, rpsw, flags;
    win = -1;
    for (int r = 3; r >= 1; r--)
      if (win < 0 && req[r-1] && eligible(r, psw)) win = r;
    if (win < 0 && req[3]) win = 0;
    if (win >= 0 && late_rank > 0 && late_cyc <= d + 1 && eligible(late_rank, psw) && late_rank > win)
      win = late_rank;

    ei_req = req[0]; fe_req = req[1]; db_req = req[2]; ret_req = req[3];
    ret_kind = rk; cur_psw = psw; pipe_idle = (d == 0);

    if (win < 0) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check_eq({tag, ".masked"}, out_flags(), 32'd0);
        @(posedge clk); #1;
      end
      return;
    end

    exc   = (win > 0);
    end_c = exc ? d + 5 : d + 3;
    code  = (win == 1) ? ei_code : (win == 2) ? fe_code : db_code;
    vec   = (win == 1) ? 32'h80 + 32'(code[5:0]) * 16 : (win == 2) ? 32'h60 : 32'h40;
    rpc   = (rk == 2'd1) ? fepc : (rk == 2'd2) ? dbpc : eipc;
    rpsw  = (rk == 2'd1) ? fepsw : (rk == 2'd2) ? dbpsw : eipsw;

    for (int i = 0; i < end_c; i++) begin
      if (i > 0) begin
        pipe_idle = (i >= d + 1);
        if (drop1 && i == 1) begin
          ei_req = 1'b0; fe_req = 1'b0; db_req = 1'b0; ret_req = 1'b0;
        end
        if (late_rank > 0 && i == late_cyc) set_req(late_rank, 1'b1);
      end
      @(negedge clk);
      flags = {24'd0, i >= 1, exc && i == d + 2,
               (exc && i == d + 3) || (!exc && i == d + 2),
               (exc && i == d + 4) || (!exc && i == d + 2),
               exc && win == 1 && i == d + 4, exc && win == 2 && i == d + 4,
               exc && win == 3 && i == d + 4, !exc && i == d + 2};
      check_eq({tag, ".flags"}, out_flags(), flags);
      if (exc && i == d + 2) begin
        check_eq({tag, ".save_sel"}, 32'(save_sel), 32'(win - 1));
        check_eq({tag, ".save_pc"}, save_pc, cur_pc);
        check_eq({tag, ".save_psw"}, save_psw, psw);
        check_eq({tag, ".save_cause"}, 32'(save_cause), 32'(code));
      end
      if (exc && i == d + 3)
        check_eq({tag, ".psw_wdata"}, psw_wdata, psw | 32'h20 | ((win > 1) ? 32'h80 : 32'h0));
      if (exc && i == d + 4)
        check_eq({tag, ".redir_pc"}, redir_pc, vec & 32'hFFFF_FFFE);
      if (!exc && i == d + 2) begin
        check_eq({tag, ".ret_psw"}, psw_wdata, rpsw);
        check_eq({tag, ".ret_pc"}, redir_pc, rpc & 32'hFFFF_FFFE);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    ei_req = 1'b0; fe_req = 1'b0; db_req = 1'b0; ret_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, out_flags(), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ei_req = 1'b0; fe_req = 1'b0; db_req = 1'b0; ret_req = 1'b0; ret_kind = 2'd0;
    ei_code = 16'h0013; fe_code = 16'h0031; db_code = 16'h0061;
    cur_pc = 32'h0000_4000; cur_psw = 32'h0;
    eipc = 32'h0000_2001; eipsw = 32'h11; fepc = 32'h1235; fepsw = 32'h3;
    dbpc = 32'h0000_3003; dbpsw = 32'h44; pipe_idle = 1'b0;
    #1;
    check_eq("rst.flags", out_flags(), 32'd0);
    check_eq("rst.data", out_data_or(), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_chk("post_rst", 2);

    // Basic EI entry
    run_txn("ei", 32'h0, 4'b0001, 2'd0, 0, 0, 1, 1'b0);
    // Masked EI, then FE taken with EI still held
    run_txn("ei_masked", 32'h20, 4'b0001, 2'd0, 0, 0, 1, 1'b0);
    run_txn("fe", 32'h20, 4'b0011, 2'd0, 0, 0, 1, 1'b0);
    // DB preempting EI during a 5-cycle drain
    run_txn("preempt", 32'h0, 4'b0001, 2'd0, 5, 3, 3, 1'b0);
    run_txn("ei_np", 32'hA0, 4'b0001, 2'd0, 0, 0, 1, 1'b0);
    run_txn("ei_after", 32'h0, 4'b0001, 2'd0, 0, 0, 1, 1'b0);
    // FERET
    run_txn("feret", 32'h0, 4'b1000, 2'd1, 0, 0, 1, 1'b0);
    // Simultaneous return and EI: EI first, return next
    run_txn("sim_ei", 32'h0, 4'b1001, 2'd0, 0, 0, 1, 1'b0);
    run_txn("sim_ret", 32'h0, 4'b1000, 2'd0, 0, 0, 1, 1'b0);
    // Illegal return kind behaves as EIRET
    run_txn("ret3", 32'h0, 4'b1000, 2'd3, 2, 0, 1, 1'b0);
    // Dropped request mid-drain completes on latched values
    run_txn("drop", 32'h0, 4'b0010, 2'd0, 3, 0, 1, 1'b1);
    // Return preempted by an exception in DRAIN
    run_txn("ret_pre", 32'h0, 4'b1000, 2'd2, 2, 1, 2, 1'b0);

    // Reset in PSWUPD clears outputs immediately
    cur_psw = 32'h0; ei_req = 1'b1; pipe_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst.psw_we", 32'(psw_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst.flags", out_flags(), 32'd0);
    check_eq("mid_rst.data", out_data_or(), 32'd0);
    ei_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle_chk("after_rst", 4);

    // Randomized transactions
    for (int t = 0; t < 300; t++) begin
      int d;
      d = int'($urandom_range(0, 4));
      ei_code = 16'($urandom); fe_code = 16'($urandom); db_code = 16'($urandom);
      cur_pc = $urandom; eipc = $urandom; eipsw = $urandom;
      fepc = $urandom; fepsw = $urandom; dbpc = $urandom; dbpsw = $urandom;
      run_txn("rnd", $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), d,
              int'($urandom_range(0, 3)), int'($urandom_range(1, d + 1)),
              1'($urandom_range(0, 1)));
      if (t % 10 == 0) idle_chk("rnd.idle", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
